// File: rtl/aes_pkg.sv
// Shared constants and types for the AES block loader slice.
package aes_pkg;

    localparam int unsigned AES_BYTES    = 16;
    localparam int unsigned STREAM_BYTES = 32;
    localparam logic [7:0]  RCON_FIRST   = 8'h01;
    localparam logic [7:0]  RCON_LAST    = 8'h36;

    typedef logic [127:0] aes_block_t;

    // Fill-side FSM: collecting stream bytes, or holding a complete block
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/aes_byte_assembler.sv
// Collects 16 plaintext then 16 key bytes from a byte stream into the fill buffer.
module aes_byte_assembler
    import aes_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       take,
    output logic       fill_full,
    output aes_block_t fill_state,
    output aes_block_t fill_key
);

    localparam logic [4:0] LAST_IDX  = 5'(STREAM_BYTES - 1);
    localparam logic [4:0] KEY_START = 5'(AES_BYTES);

    fill_state_t state_q;
    fill_state_t state_d;
    logic [4:0]  cnt_q;
    logic        accept;

    assign accept    = s_valid && (state_q == ST_FILL);
    assign s_ready   = (state_q == ST_FILL);
    assign fill_full = (state_q == ST_FULL);

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: full after the last stream byte, back to filling once the block is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (accept && (cnt_q == LAST_IDX)) state_d = ST_FULL;
            ST_FULL: if (take) state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // Byte counter and fill buffer; counter wraps 31 -> 0 on its own
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            fill_state <= '0;
            fill_key   <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q < KEY_START) begin
                fill_state[{cnt_q[3:0], 3'b000} +: 8] <= s_data;
            end else begin
                fill_key[{cnt_q[3:0], 3'b000} +: 8] <= s_data;
            end
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// Double-buffered block loader feeding the AES round pipeline's new-block inputs.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter bit         PRE_XOR   = 1'b1,
    parameter logic [7:0] RCON_INIT = RCON_FIRST
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         slot_free,
    output logic [127:0] out_state,
    output logic [127:0] out_key,
    output logic         empty,
    output logic [7:0]   rcon_out,
    output logic [15:0]  blk_cnt
);

    aes_block_t  fill_state;
    aes_block_t  fill_key;
    aes_block_t  hold_state_q;
    aes_block_t  hold_key_q;
    logic        fill_full;
    logic        hold_valid_q;
    logic        consume;
    logic        transfer;
    logic [15:0] blk_cnt_q;

    aes_byte_assembler u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .take       (transfer),
        .fill_full  (fill_full),
        .fill_state (fill_state),
        .fill_key   (fill_key)
    );

    // Consume and transfer may coincide: the hold slot is refilled in the same edge it drains
    assign consume  = hold_valid_q && slot_free;
    assign transfer = fill_full && (!hold_valid_q || consume);

    // Hold register, occupancy flag and handed-off block counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_state_q <= '0;
            hold_key_q   <= '0;
            hold_valid_q <= 1'b0;
            blk_cnt_q    <= '0;
        end else begin
            if (transfer) begin
                hold_state_q <= PRE_XOR ? (fill_state ^ fill_key) : fill_state;
                hold_key_q   <= fill_key;
                hold_valid_q <= 1'b1;
            end else if (consume) begin
                hold_valid_q <= 1'b0;
            end
            if (consume) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
        end
    end

    assign out_state = hold_state_q;
    assign out_key   = hold_key_q;
    assign empty     = !hold_valid_q;
    assign rcon_out  = hold_valid_q ? RCON_INIT : 8'h00;
    assign blk_cnt   = blk_cnt_q;

endmodule
